// File: rtl/maze_engine.sv
// maze_engine: loadable COLS x ROWS wall map, one player, synchronised U/D/L/R step commands with
// border/wall collision, goal detection and a saturating step counter. Define MAZE_TRAIL_EN for the visited-cell trail.
module maze_engine #(
    parameter int COLS    = 40,
    parameter int ROWS    = 20,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = COLS - 1,
    parameter int GOAL_Y  = ROWS - 1,
    localparam int N  = COLS * ROWS,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic [N-1:0]  wall_in,
    input  logic          start,
    input  logic          U,
    input  logic          D,
    input  logic          L,
    input  logic          R,
    output logic [N-1:0]  wall_q,
    output logic [N-1:0]  player_q,
    output logic [N-1:0]  trail_q,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [15:0]   step_cnt,
    output logic          move_able,
    output logic          win,
    output logic          bump
);

    typedef enum logic [1:0] {IDLE, PLAY, WIN} state_t;

    localparam logic [XW-1:0] START_XV = XW'(START_X);
    localparam logic [YW-1:0] START_YV = YW'(START_Y);
    localparam logic [XW-1:0] GOAL_XV  = XW'(GOAL_X);
    localparam logic [YW-1:0] GOAL_YV  = YW'(GOAL_Y);
    localparam logic [XW-1:0] XMAX     = XW'(COLS - 1);
    localparam logic [YW-1:0] YMAX     = YW'(ROWS - 1);
    localparam logic [N-1:0]  START_MASK = {{(N-1){1'b0}}, 1'b1} << (START_Y * COLS + START_X);

    function automatic logic [N-1:0] cellMask(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << (int'(y) * COLS + int'(x));
    endfunction

    state_t        state_q;
    logic [XW-1:0] pos_x_q, tx_d;
    logic [YW-1:0] pos_y_q, ty_d;
    logic [15:0]   step_q;
    logic          move_able_q, win_q, bump_q;
    logic [3:0]    sync1_q, sync2_q, sync3_q, edge_q;
    logic [N-1:0]  targetMask;
    logic          cmdValid, inBounds, hitWall, atGoal, inPlay, moveOk, moveBad, restart;

    // Decode the highest-priority edge (U > D > L > R) into a target cell and judge it.
    always_comb begin
        tx_d     = pos_x_q;
        ty_d     = pos_y_q;
        cmdValid = 1'b0;
        inBounds = 1'b0;
        if (edge_q[3]) begin
            cmdValid = 1'b1;
            inBounds = (pos_y_q != '0);
            ty_d     = pos_y_q - 1'b1;
        end else if (edge_q[2]) begin
            cmdValid = 1'b1;
            inBounds = (pos_y_q != YMAX);
            ty_d     = pos_y_q + 1'b1;
        end else if (edge_q[1]) begin
            cmdValid = 1'b1;
            inBounds = (pos_x_q != '0);
            tx_d     = pos_x_q - 1'b1;
        end else if (edge_q[0]) begin
            cmdValid = 1'b1;
            inBounds = (pos_x_q != XMAX);
            tx_d     = pos_x_q + 1'b1;
        end
        targetMask = cellMask(tx_d, ty_d);
        hitWall    = |(wall_q & targetMask);
        atGoal     = (pos_x_q == GOAL_XV) && (pos_y_q == GOAL_YV);
        // Once the goal is reached the FSM is already leaving PLAY, so late commands are dropped.
        inPlay     = (state_q == PLAY) && !atGoal;
        moveOk     = inPlay && cmdValid && inBounds && !hitWall;
        moveBad    = inPlay && cmdValid && !(inBounds && !hitWall);
        restart    = load || ((state_q == WIN) && start);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            edge_q      <= '0;
            state_q     <= IDLE;
            wall_q      <= '0;
            pos_x_q     <= START_XV;
            pos_y_q     <= START_YV;
            player_q    <= START_MASK;
            step_q      <= '0;
            move_able_q <= 1'b0;
            win_q       <= 1'b0;
            bump_q      <= 1'b0;
        end else begin
            sync1_q <= {U, D, L, R};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
            bump_q  <= 1'b0;
            if (restart) begin
                pos_x_q  <= START_XV;
                pos_y_q  <= START_YV;
                player_q <= START_MASK;
                step_q   <= '0;
                win_q    <= 1'b0;
                if (load) begin
                    wall_q      <= wall_in;
                    state_q     <= IDLE;
                    move_able_q <= 1'b0;
                end else begin
                    state_q     <= PLAY;
                    move_able_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q     <= PLAY;
                            move_able_q <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (atGoal) begin
                            state_q     <= WIN;
                            move_able_q <= 1'b0;
                            win_q       <= 1'b1;
                        end else if (moveOk) begin
                            pos_x_q  <= tx_d;
                            pos_y_q  <= ty_d;
                            player_q <= targetMask;
                            if (step_q != 16'hFFFF) begin
                                step_q <= step_q + 16'd1;
                            end
                        end else if (moveBad) begin
                            bump_q <= 1'b1;
                        end
                    end
                    WIN: ;
                    default: begin
                        state_q     <= IDLE;
                        move_able_q <= 1'b0;
                        win_q       <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MAZE_TRAIL_EN
    logic [N-1:0] trail_r_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            trail_r_q <= START_MASK;
        end else if (restart) begin
            trail_r_q <= START_MASK;
        end else if (moveOk) begin
            trail_r_q <= trail_r_q | targetMask;
        end
    end

    assign trail_q = trail_r_q;
`else
    assign trail_q = '0;
`endif

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign step_cnt  = step_q;
    assign move_able = move_able_q;
    assign win       = win_q;
    assign bump      = bump_q;

endmodule
